// File: rtl/ma_sched.sv
// ma_sched: round-robin scheduler in front of one shared (a+b)*(c+d) datapath.
// Requesters are arbitrated in IDLE. The winner's operands are captured, then
// summed (SUM) and multiplied (MUL). The tagged result is offered in DONE on a
// valid/ready channel. Only one operation is in flight at a time.
// Build option: define MA_SCHED_RR_EN for rotating-pointer round-robin
// arbitration. Leave it undefined for fixed lowest-index-wins priority.
module ma_sched #(
  parameter int W = 4,
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  input  logic [N*W-1:0]   req_c,
  input  logic [N*W-1:0]   req_d,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*W+1:0]   res_data,
  output logic [IW-1:0]    res_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SUM, MUL, DONE} state_t;

  state_t state_reg, state_next;

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];
  logic [W-1:0] c_arr [N];
  logic [W-1:0] d_arr [N];

  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic          handshake;
  logic          res_fire;

  logic [W-1:0]  op_a_reg, op_b_reg, op_c_reg, op_d_reg;
  logic [IW-1:0] id_reg;
  logic [W:0]    s1_reg, s2_reg;

  // Unpack the flat operand buses into per-requester lanes.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
      assign c_arr[gi] = req_c[gi*W +: W];
      assign d_arr[gi] = req_d[gi*W +: W];
    end
  endgenerate

`ifdef MA_SCHED_RR_EN
  logic [IW-1:0] ptr_reg;
  logic [IW:0]   cand;

  // Round-robin search: first valid requester at or after ptr, wrapping at N.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_reg} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!grant_found && req_valid[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the one granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (handshake) begin
      ptr_reg <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
    end
  end
`else
  // Fixed priority: scanning downward lets the lowest valid index win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(k);
      end
    end
  end
`endif

  // Grant strobe: one-hot, IDLE only, suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && !rst && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign handshake = |(req_valid & req_ready);
  assign res_valid = (state_reg == DONE);
  assign res_fire  = res_valid & res_ready;
  assign busy      = (state_reg != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: fixed walk through SUM and MUL, hold DONE until accepted.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = SUM;
      SUM:     state_next = MUL;
      MUL:     state_next = DONE;
      DONE:    if (res_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on grant, sum stage, product stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_reg <= '0;
      op_b_reg <= '0;
      op_c_reg <= '0;
      op_d_reg <= '0;
      id_reg   <= '0;
      s1_reg   <= '0;
      s2_reg   <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      if (handshake) begin
        op_a_reg <= a_arr[grant_idx];
        op_b_reg <= b_arr[grant_idx];
        op_c_reg <= c_arr[grant_idx];
        op_d_reg <= d_arr[grant_idx];
        id_reg   <= grant_idx;
      end
      if (state_reg == SUM) begin
        s1_reg <= {1'b0, op_a_reg} + {1'b0, op_b_reg};
        s2_reg <= {1'b0, op_c_reg} + {1'b0, op_d_reg};
      end
      if (state_reg == MUL) begin
        res_data <= (2*W+2)'(s1_reg) * (2*W+2)'(s2_reg);
        res_id   <= id_reg;
      end
    end
  end

endmodule

// File: tb/tb_ma_sched.sv
// Directed testbench for ma_sched (W=4, N=4). Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, well away from the
// rising edge. Expectations adapt to the MA_SCHED_RR_EN build option.
module tb_ma_sched;
  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b, req_c, req_d;
  logic           res_valid;
  logic           res_ready;
  logic [2*W+1:0] res_data;
  logic [1:0]     res_id;
  logic           busy;

  int total = 0;
  int bad   = 0;

  ma_sched #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_ops(input int i, input logic [W-1:0] a, b, c, d);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
    req_d[i*W +: W] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (res_data !== 10'd0) begin bad++; $display("FAIL reset_res_data got=%0d want=0", res_data); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL reset_res_id got=%0d want=0", res_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk); rst = 1'b0; req_valid = '0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b want=0", busy); end
    $display("reset: outputs checked during and after reset");
  endtask

  // One op on requester rq; expects grant, 3-cycle latency, then IDLE.
  task automatic test_single_op(input string nm, input int rq, input logic [W-1:0] a, b, c, d,
                                input logic [2*W+1:0] exp_data);
    set_ops(rq, a, b, c, d); res_ready = 1'b1;
    @(negedge clk); req_valid = 4'(1 << rq); #1;
    total++; if (req_ready !== 4'(1 << rq)) begin bad++; $display("FAIL %s_grant got=%b want=%b", nm, req_ready, 4'(1 << rq)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_idle got=%b want=0", nm, busy); end
    @(negedge clk); req_valid = '0; #1;
    total++; if (busy !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL %s_sum got busy=%b valid=%b want 1/0", nm, busy, res_valid); end
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL %s_mul_valid got=%b want=0", nm, res_valid); end
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL %s_done_valid got=%b want=1", nm, res_valid); end
    total++; if (res_data !== exp_data) begin bad++; $display("FAIL %s_data got=%0d want=%0d", nm, res_data, exp_data); end
    total++; if (res_id !== 2'(rq)) begin bad++; $display("FAIL %s_id got=%0d want=%0d", nm, res_id, rq); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL %s_after got busy=%b valid=%b want 0/0", nm, busy, res_valid); end
    total++; if (res_data !== exp_data) begin bad++; $display("FAIL %s_data_hold got=%0d want=%0d", nm, res_data, exp_data); end
    $display("%s: requester %0d result %0d", nm, rq, res_data);
  endtask

  task automatic test_backpressure;
    logic [3:0] exp_g;
    logic [9:0] exp_d;
    logic [1:0] exp_i;
`ifdef MA_SCHED_RR_EN
    exp_g = 4'b1000; exp_d = 10'd4;  exp_i = 2'd3;
`else
    exp_g = 4'b0001; exp_d = 10'd16; exp_i = 2'd0;
`endif
    set_ops(1, 1, 2, 3, 4); set_ops(0, 2, 2, 2, 2); set_ops(3, 1, 1, 1, 1);
    res_ready = 1'b0;
    @(negedge clk); req_valid = 4'b0010; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b want=0010", req_ready); end
    @(negedge clk); req_valid = 4'b1001; #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_sum_ready got=%b want=0000", req_ready); end
    @(negedge clk); #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_mul_ready got=%b want=0000", req_ready); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      total++; if (res_valid !== 1'b1 || res_data !== 10'd21 || res_id !== 2'd1 || req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_hold%0d got valid=%b data=%0d id=%0d ready=%b want 1/21/1/0000", k, res_valid, res_data, res_id, req_ready);
      end
    end
    @(negedge clk); res_ready = 1'b1; #1;
    total++; if (res_valid !== 1'b1 || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_handshake got valid=%b ready=%b want 1/0000", res_valid, req_ready); end
    @(negedge clk); #1;
    total++; if (req_ready !== exp_g) begin bad++; $display("FAIL bp_next_grant got=%b want=%b", req_ready, exp_g); end
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b1 || res_data !== exp_d || res_id !== exp_i) begin
      bad++; $display("FAIL bp_next_result got valid=%b data=%0d id=%0d want 1/%0d/%0d", res_valid, res_data, res_id, exp_d, exp_i);
    end
    @(negedge clk);
    $display("backpressure: held 6 cycles, then id %0d served", exp_i);
  endtask

  task automatic test_reset_mid_op;
    set_ops(2, 1, 1, 1, 1); set_ops(0, 2, 2, 2, 2); res_ready = 1'b1;
    @(negedge clk); req_valid = 4'b0100; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmid_grant got=%b want=0100", req_ready); end
    @(negedge clk); req_valid = 4'b1001;
    @(negedge clk); #1; rst = 1'b1; #1;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 10'd0 || res_id !== 2'd0 || req_ready !== 4'b0000) begin
      bad++; $display("FAIL rmid_async got valid=%b busy=%b data=%0d id=%0d ready=%b want all 0", res_valid, busy, res_data, res_id, req_ready);
    end
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_held got valid=%b ready=%b want 0/0000", res_valid, req_ready); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first_grant got=%b want=0001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    total++; if (res_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rmid_sum got valid=%b busy=%b want 0/1", res_valid, busy); end
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rmid_mul got valid=%b want=0", res_valid); end
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b1 || res_data !== 10'd16 || res_id !== 2'd0) begin
      bad++; $display("FAIL rmid_result got valid=%b data=%0d id=%0d want 1/16/0", res_valid, res_data, res_id);
    end
    @(negedge clk);
    $display("reset_mid_op: discarded op, requester 0 served after release");
  endtask

  // Back-to-back grants with res_ready high: one grant every 4 cycles.
  task automatic test_back_to_back;
    int len;
    int g;
    logic [3:0] rv;
    logic [3:0] exp_ready;
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 4'(i), 4'd1, 4'd2, 4'd3);
    res_ready = 1'b1;
`ifdef MA_SCHED_RR_EN
    len = 17;
`else
    len = 16;
`endif
    for (int k = 0; k < len; k++) begin
`ifdef MA_SCHED_RR_EN
      rv = 4'b1111; g = (k / 4) % 4;
`else
      rv = (k < 12) ? 4'b1010 : 4'b1000; g = (k < 12) ? 1 : 3;
`endif
      exp_ready = (k % 4 == 0) ? 4'(1 << g) : 4'b0000;
      @(negedge clk); req_valid = rv; #1;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL b2b_ready_c%0d got=%b want=%b", k, req_ready, exp_ready); end
      if (k % 4 == 3) begin
        total++; if (res_valid !== 1'b1 || res_id !== 2'(g) || res_data !== 10'((g + 1) * 5)) begin
          bad++; $display("FAIL b2b_result_c%0d got valid=%b data=%0d id=%0d want 1/%0d/%0d", k, res_valid, res_data, res_id, (g + 1) * 5, g);
        end
      end
      if (k % 4 == 0) $display("back_to_back: cycle %0d grant %b", k, req_ready);
    end
    req_valid = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single_op("single", 2, 4'd3, 4'd5, 4'd7, 4'd2, 10'd72);
    test_single_op("max", 0, 4'd15, 4'd15, 4'd15, 4'd15, 10'd900);
    test_backpressure;
    test_reset_mid_op;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
